// File: rtl/dram_read_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_read_responder_pkg
// Description : Shared types and constants for the DRAM read responder:
//               FSM state encoding, buffer depth and word byte stride.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_read_responder_pkg;

  // Responder control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of response entries between memory and consumer
  localparam int BUF_DEPTH = 2;

  // Bits per byte; the address advances by DATA_WIDTH/BITS_PER_BYTE per word
  localparam int BITS_PER_BYTE = 8;

  // Byte stride of one data word of the given bit width
  function automatic int word_stride(input int data_width);
    return data_width / BITS_PER_BYTE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dram_read_responder_rsp_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : rsp_skid_buf
// Description : Two-entry response FIFO holding data word plus last flag.
//               Push and pop in the same cycle leave the occupancy unchanged;
//               a push into a full buffer is only accepted alongside a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module rsp_skid_buf
  import dram_read_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] r_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  r_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_push;
  logic                  w_pop;

  // Qualify requests so the buffer can neither overflow nor underflow
  always_comb begin
    w_pop  = pop && (r_count != 2'd0);
    w_push = push && ((r_count != 2'd2) || w_pop);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '{default: '0};
      r_last   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= push_data;
        r_last[r_wr_ptr] <= push_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head of queue and status flags
  always_comb begin
    head_data = r_data[r_rd_ptr];
    head_last = r_last[r_rd_ptr];
    full      = (r_count == 2'd2);
    empty     = (r_count == 2'd0);
    count     = r_count;
  end

endmodule
`default_nettype wire

// File: rtl/dram_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_read_responder
// Description : Accepts a burst read request (start address, word count),
//               issues one memory read per word with fixed one-cycle read
//               latency and returns the words as a valid/ready beat stream
//               through a two-entry response buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_read_responder
  import dram_read_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  dram_ack,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  len_err
);

  localparam int                  STRIDE    = word_stride(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRIDE);

  state_t                r_state;
  state_t                w_state_next;

  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_ack_prev;
  logic                  r_inflight;
  logic                  r_inflight_last;

  logic                  w_ack;
  logic                  w_len_zero;
  logic                  w_last_issue;
  logic                  w_rd_en;
  logic                  w_pop;
  logic [2:0]            w_load;

  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_last;
  logic                  w_buf_full;
  logic                  w_buf_empty;
  logic [1:0]            w_buf_count;

  // Request acceptance and read issue decisions
  always_comb begin
    // Ack only in IDLE, never two cycles running, never while in reset
    w_ack        = !rst && (r_state == ST_IDLE) && issue_req && !r_ack_prev;
    w_len_zero   = (len == '0);
    w_pop        = !w_buf_empty && rd_ready;
    // Outstanding words (in flight + buffered) after this cycle's pop
    w_load       = 3'(w_buf_count) + 3'(r_inflight) - 3'(w_pop);
    w_rd_en      = (r_state == ST_READ) && (r_remaining != '0) &&
                   (w_load < 3'd2) && !(w_buf_full && !w_pop);
    w_last_issue = w_rd_en && (r_remaining == LEN_WIDTH'(1));
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_ack && !w_len_zero) w_state_next = ST_READ;
      end
      ST_READ: begin
        if (w_last_issue) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pop && w_head_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Address/length counters and read-return tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr      <= '0;
      r_remaining     <= '0;
      r_ack_prev      <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_ack_prev      <= w_ack;
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_last_issue;
      if (w_ack && !w_len_zero) begin
        r_cur_addr  <= addr;
        r_remaining <= len;
      end else if (w_rd_en) begin
        r_cur_addr  <= r_cur_addr + ADDR_STEP;
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
    end
  end

  // Read data lands in the buffer exactly one cycle after its strobe
  rsp_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (mem_rdata),
    .push_last (r_inflight_last),
    .pop       (w_pop),
    .head_data (w_head_data),
    .head_last (w_head_last),
    .full      (w_buf_full),
    .empty     (w_buf_empty),
    .count     (w_buf_count)
  );

  // Output drive
  always_comb begin
    dram_ack  = w_ack;
    len_err   = w_ack && w_len_zero;
    mem_rd_en = w_rd_en;
    mem_addr  = r_cur_addr;
    rd_valid  = !w_buf_empty;
    rd_data   = w_head_data;
    rd_last   = w_head_last && !w_buf_empty;
    busy      = (r_state != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_read_responder
// Description : Directed self-checking bench for dram_read_responder with a
//               one-cycle-latency memory model and an expected-beat queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_read_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_req;
  logic [31:0] addr;
  logic [15:0] len;
  logic        dram_ack;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_ready;
  logic        busy;
  logic        len_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [31:0] addr_q [$];
  logic [32:0] beat_q [$];

  int   ack_count = 0;
  int   issued    = 0;
  int   xfered    = 0;
  logic prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;
  logic last_xfer_prev = 1'b0;

  dram_read_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .LEN_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .issue_req (issue_req),
    .addr      (addr),
    .len       (len),
    .dram_ack  (dram_ack),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C ^ (a << 3);
  endfunction

  // Memory model: data valid exactly one cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= data_of(mem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input int l);
    for (int i = 0; i < l; i++) begin
      logic [31:0] ai;
      ai = a + 32'(i * 4);
      addr_q.push_back(ai);
      beat_q.push_back({(i == l - 1), data_of(ai)});
    end
  endtask

  task automatic wait_ack(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dram_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_seen"}, 64'(got), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy && !rd_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, 64'(done), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dram_ack"},  64'(dram_ack),  64'd0);
    chk({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_rd_valid"},  64'(rd_valid),  64'd0);
    chk({tag, "_rd_last"},   64'(rd_last),   64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_len_err"},   64'(len_err),   64'd0);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_rd_data"},   64'(rd_data),   64'd0);
  endtask

  // Protocol monitor and scoreboard
  always @(negedge clk) begin
    logic pop;
    logic [32:0] exp_beat;
    if (rst) begin
      issued         = 0;
      xfered         = 0;
      prev_hold      = 1'b0;
      last_xfer_prev = 1'b0;
    end else begin
      pop = rd_valid && rd_ready;
      if (dram_ack) begin
        ack_count++;
        chk("ack_only_idle", 64'(busy), 64'd0);
      end
      if (len_err) chk("len_err_with_ack", 64'(dram_ack), 64'd1);
      if (prev_hold) begin
        chk("hold_valid", 64'(rd_valid), 64'd1);
        chk("hold_data",  64'(rd_data),  64'(prev_data));
        chk("hold_last",  64'(rd_last),  64'(prev_last));
      end
      if (last_xfer_prev) chk("busy_after_last", 64'(busy), 64'd0);
      if (mem_rd_en) begin
        chk("no_overflow", 64'((issued - xfered - (pop ? 1 : 0)) < 2), 64'd1);
        chk("addr_expected", 64'(addr_q.size() != 0), 64'd1);
        if (addr_q.size() != 0) chk("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        issued++;
      end
      if (pop) begin
        chk("beat_expected", 64'(beat_q.size() != 0), 64'd1);
        if (beat_q.size() != 0) begin
          exp_beat = beat_q.pop_front();
          chk("beat_data", 64'(rd_data), 64'(exp_beat[31:0]));
          chk("beat_last", 64'(rd_last), 64'(exp_beat[32]));
        end
        xfered++;
      end
      prev_hold      = rd_valid && !rd_ready;
      prev_data      = rd_data;
      prev_last      = rd_last;
      last_xfer_prev = pop && rd_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nack;
    logic [3:0] pat;

    rst = 1'b1; issue_req = 1'b0; addr = '0; len = '0; rd_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: basic 4-word burst, sustained ready
    push_req(32'h1000_0000, 4);
    rd_ready = 1'b1; addr = 32'h1000_0000; len = 16'd4; issue_req = 1'b1;
    wait_ack("t1");
    chk("t1_len_err", 64'(len_err), 64'd0);
    @(posedge clk); #1;
    issue_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_latency_early", 64'(rd_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_beat_valid", 64'(rd_valid), 64'd1);
      chk("t1_beat_last",  64'(rd_last),  64'(i == 3));
    end
    @(negedge clk);
    chk("t1_busy_drop", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Test 2: 4 words with ready toggling 1,0,0,1
    push_req(32'h1000_0100, 4);
    addr = 32'h1000_0100; len = 16'd4; issue_req = 1'b1;
    wait_ack("t2");
    @(posedge clk); #1;
    issue_req = 1'b0;
    pat = 4'b1001;
    for (int i = 0; i < 24; i++) begin
      rd_ready = pat[i % 4];
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    wait_idle("t2");
    chk("t2_all_beats", 64'(beat_q.size()), 64'd0);
    @(posedge clk); #1;

    // Test 3: zero-length request
    base = ack_count;
    addr = 32'h3000_0000; len = 16'd0; issue_req = 1'b1;
    wait_ack("t3");
    chk("t3_len_err", 64'(len_err), 64'd1);
    @(posedge clk); #1;
    issue_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_one_ack", 64'(ack_count - base), 64'd1);
    @(posedge clk); #1;

    // Test 4: request held high across a 2-word transfer
    base = ack_count;
    nack = 0;
    push_req(32'h4000_0000, 2);
    push_req(32'h4000_0000, 2);
    addr = 32'h4000_0000; len = 16'd2; issue_req = 1'b1;
    for (int i = 0; i < 60 && nack < 2; i++) begin
      @(negedge clk);
      if (dram_ack) nack++;
    end
    chk("t4_second_ack", 64'(nack), 64'd2);
    @(posedge clk); #1;
    issue_req = 1'b0;
    wait_idle("t4");
    repeat (3) @(negedge clk);
    chk("t4_two_acks", 64'(ack_count - base), 64'd2);
    @(posedge clk); #1;

    // Test 5: reset mid-READ after two reads issued
    push_req(32'h5000_0000, 4);
    addr = 32'h5000_0000; len = 16'd4; issue_req = 1'b1;
    wait_ack("t5");
    @(posedge clk); #1;
    issue_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    addr_q.delete();
    beat_q.delete();
    @(negedge clk);
    check_all_zero("t5_after_rst");
    repeat (6) @(negedge clk);
    chk("t5_no_beats", 64'(rd_valid), 64'd0);
    @(posedge clk); #1;
    push_req(32'h2000_0040, 4);
    addr = 32'h2000_0040; len = 16'd4; issue_req = 1'b1;
    wait_ack("t5_new");
    @(posedge clk); #1;
    issue_req = 1'b0;
    wait_idle("t5_new");
    @(posedge clk); #1;

    // Test 6: address wrap
    push_req(32'hFFFF_FFFC, 2);
    addr = 32'hFFFF_FFFC; len = 16'd2; issue_req = 1'b1;
    wait_ack("t6");
    @(posedge clk); #1;
    issue_req = 1'b0;
    wait_idle("t6");

    repeat (3) @(negedge clk);
    chk("final_addr_q_empty", 64'(addr_q.size()), 64'd0);
    chk("final_beat_q_empty", 64'(beat_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_read_responder.md
DRAM_READ_RESPONDER -- requirements
Module: dram_read_responder

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, request/memory address width; DATA_WIDTH, default 32, data word width; LEN_WIDTH, default 16, request length width.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- issue_req  in  1  read request, held high until acked
- addr  in  ADDR_WIDTH  start byte address
- len  in  LEN_WIDTH  number of words
- dram_ack  out  1  one-cycle request-accept pulse
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  memory word byte address
- mem_rdata  in  DATA_WIDTH  memory data, valid exactly 1 cycle after mem_rd_en
- rd_valid  out  1  response beat valid
- rd_data  out  DATA_WIDTH  response word
- rd_last  out  1  final beat of request
- rd_ready  in  1  consumer accepts beat
- busy  out  1  request in progress
- len_err  out  1  one-cycle pulse, zero-length request dropped

Function
REQ-004 FSM states: IDLE, READ, DRAIN.
REQ-005 In IDLE with issue_req=1 and dram_ack=0 in the previous cycle, SHALL pulse dram_ack for exactly one cycle and capture addr and len on that edge.
REQ-006 SHALL NOT assert dram_ack in READ or DRAIN; further requests wait with issue_req held.
REQ-007 If captured len=0: pulse len_err on the ack cycle, generate no beats, and stay in IDLE.
REQ-008 If captured len>0: go to READ with cur_addr=addr, remaining=len, busy=1.
REQ-009 In READ, assert mem_rd_en with mem_addr=cur_addr whenever in-flight reads plus buffered beats are below 2.
REQ-010 On each mem_rd_en: cur_addr += DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH), remaining -= 1.
REQ-011 When the last read issues (remaining becomes 0), go to DRAIN.
REQ-012 mem_rdata SHALL be written into the response buffer on the cycle after mem_rd_en; the buffer SHALL never overflow.
REQ-013 rd_valid=1 whenever the buffer is non-empty; rd_data/rd_last stable while rd_valid=1 and rd_ready=0.
REQ-014 A beat transfers when rd_valid and rd_ready are both 1.
REQ-015 rd_last=1 only on the beat of word number len.
REQ-016 In DRAIN, return to IDLE and drop busy on the cycle after the rd_last beat transfers.
REQ-017 A new issue_req may be acked no earlier than the first IDLE cycle.
REQ-018 Sustained rd_ready=1 SHALL give one beat per cycle after a 2-cycle initial latency (ack edge to first rd_valid).
REQ-019 Simultaneous buffer write and read SHALL keep the occupancy unchanged.

Reset
REQ-020 While rst=1, at the next clock edge: state=IDLE; dram_ack, mem_rd_en, rd_valid, rd_last, busy and len_err all 0; mem_addr and rd_data 0; buffer empty; counters 0.
REQ-021 Reset during READ or DRAIN SHALL discard all in-flight reads and buffered beats; mem_rdata arriving the cycle after reset SHALL be ignored.

Structure
REQ-022 A shared package SHALL hold the FSM state enum (IDLE/READ/DRAIN) and the word-byte-stride constant.
REQ-023 The 2-entry response buffer SHALL be a sub-module rsp_skid_buf (entries of data + last, with push, pop, full and empty).

Verification
REQ-024 addr=0x10000000, len=4, rd_ready=1 -> one dram_ack pulse; mem_addr 0x10000000, 0x10000004, 0x10000008, 0x1000000C; 4 beats; rd_last on beat 4; busy low the cycle after.
REQ-025 len=4 with rd_ready toggling 1,0,0,1,... -> no lost or duplicated words, data order preserved, at most 2 buffered beats, mem_rd_en stalls while full.
REQ-026 len=0 -> dram_ack and len_err pulse together; no mem_rd_en; busy stays 0.
REQ-027 issue_req held high across a len=2 transfer -> second dram_ack only after return to IDLE, and exactly 2 acks total.
REQ-028 rst=1 mid-READ after 2 of 4 words -> all outputs 0 next cycle; no beats follow; a new request then completes normally.
REQ-029 addr=0xFFFFFFFC, len=2 -> mem_addr 0xFFFFFFFC then 0x00000000.
